// File: rtl/conv_encoder_punct_pkg.sv
// conv_encoder_punct_pkg
//   Shared 802.11 TX definitions: SIGNAL-field rate codes, the internal
//   coding-rate enum, puncture periods/patterns and small helpers used by
//   the punctured convolutional encoder.
package conv_encoder_punct_pkg;

    // SIGNAL-field RATE codes (R1..R4)
    localparam logic [3:0] RATE_6M  = 4'b1011;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b1010;
    localparam logic [3:0] RATE_18M = 4'b1110;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1101;
    localparam logic [3:0] RATE_48M = 4'b1000;
    localparam logic [3:0] RATE_54M = 4'b1100;

    typedef enum logic [1:0] {
        RATE_1_2,
        RATE_2_3,
        RATE_3_4
    } rate_e;

    localparam int unsigned PERIOD_1_2 = 1;
    localparam int unsigned PERIOD_2_3 = 2;
    localparam int unsigned PERIOD_3_4 = 3;

    // Bit p set: output A (or B) is emitted at puncture phase p.
    localparam logic [2:0] PUNCT_A_1_2 = 3'b001;
    localparam logic [2:0] PUNCT_B_1_2 = 3'b001;
    localparam logic [2:0] PUNCT_A_2_3 = 3'b011;
    localparam logic [2:0] PUNCT_B_2_3 = 3'b001;
    localparam logic [2:0] PUNCT_A_3_4 = 3'b011;
    localparam logic [2:0] PUNCT_B_3_4 = 3'b101;

    function automatic rate_e rate_map(input logic [3:0] code);
        case (code)
            RATE_9M, RATE_18M, RATE_36M, RATE_54M: rate_map = RATE_3_4;
            RATE_48M:                              rate_map = RATE_2_3;
            default:                               rate_map = RATE_1_2;
        endcase
    endfunction

    function automatic int unsigned punct_period(input rate_e r);
        case (r)
            RATE_2_3: punct_period = PERIOD_2_3;
            RATE_3_4: punct_period = PERIOD_3_4;
            default:  punct_period = PERIOD_1_2;
        endcase
    endfunction

    // (p + n) mod period of rate r
    function automatic logic [1:0] phase_add(input logic [1:0] p, input int unsigned n,
                                             input rate_e r);
        int unsigned s;
        s = (32'(p) + n) % punct_period(r);
        return s[1:0];
    endfunction

    function automatic logic emit_a(input rate_e r, input logic [1:0] p);
        case (r)
            RATE_2_3: emit_a = PUNCT_A_2_3[p];
            RATE_3_4: emit_a = PUNCT_A_3_4[p];
            default:  emit_a = PUNCT_A_1_2[p];
        endcase
    endfunction

    function automatic logic emit_b(input rate_e r, input logic [1:0] p);
        case (r)
            RATE_2_3: emit_b = PUNCT_B_2_3[p];
            RATE_3_4: emit_b = PUNCT_B_3_4[p];
            default:  emit_b = PUNCT_B_1_2[p];
        endcase
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer
//   Two-entry AXI4-Stream register slice with a registered s_ready.
//   Ports:
//     aclk, aresetn         clock, asynchronous active-low reset
//     s_data/s_valid/s_ready  upstream beat
//     m_data/m_valid/m_ready  downstream beat (head entry, stable while stalled)
module axis_skid_buffer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        count_q;
    logic [1:0]        count_next;
    logic              ready_q;
    logic              push;
    logic              pop;

    assign push    = s_valid & ready_q;
    assign pop     = (count_q != 2'd0) & m_ready;
    assign s_ready = ready_q;
    assign m_valid = (count_q != 2'd0);
    assign m_data  = head_q;

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + 2'd1;
            2'b01:   count_next = count_q - 2'd1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_next;
            ready_q <= (count_next != 2'd2);
            case (count_q)
                2'd0: if (push) head_q <= s_data;
                2'd1: begin
                    if (push && pop) head_q <= s_data;
                    else if (push)   tail_q <= s_data;
                end
                // full: ready is low, so only a pop can happen
                2'd2: if (pop) head_q <= tail_q;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conv_encoder_punct.sv
// conv_encoder_punct
//   802.11 convolutional encoder (constraint length K, generators G0/G1)
//   with per-packet puncturing to 1/2, 2/3 or 3/4, AXI4-Stream in/out.
//   Ports:
//     aclk, aresetn                    clock, asynchronous active-low reset
//     s_axis_tdata/tuser/tvalid/tready/tlast
//                                      uncoded beat, bit 0 earliest; tuser =
//                                      RATE code sampled on a packet's first beat
//     m_axis_tdata/tcount/tuser/tvalid/tready/tlast
//                                      coded beat, LSB-packed, tcount valid bits
module conv_encoder_punct
    import conv_encoder_punct_pkg::*;
#(
    parameter int unsigned    WIDTH = 24,
    parameter int unsigned    K     = 7,
    parameter logic [K-1:0]   G0    = 7'o133,
    parameter logic [K-1:0]   G1    = 7'o171
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [WIDTH-1:0]                 s_axis_tdata,
    input  logic [3:0]                       s_axis_tuser,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [2*WIDTH-1:0]               m_axis_tdata,
    output logic [$clog2(2*WIDTH+1)-1:0]     m_axis_tcount,
    output logic [3:0]                       m_axis_tuser,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast
);

    localparam int unsigned H   = K - 1;
    localparam int unsigned CW  = 2 * WIDTH;
    localparam int unsigned TCW = $clog2(2*WIDTH+1);
    localparam int unsigned DW  = CW + TCW + 4 + 1;

    logic               s_hs;
    logic [H-1:0]       hist_q;     // hist_q[H-1] is the most recent past bit
    logic [1:0]         phase_q;
    rate_e              rate_q;
    logic [3:0]         tuser_q;
    logic               in_pkt_q;   // low: next accepted beat starts a packet

    rate_e              rate_cur;
    logic [3:0]         tuser_cur;
    logic [WIDTH+H-1:0] ext;
    logic [CW-1:0]      coded;
    logic [TCW-1:0]     count;
    logic [DW-1:0]      beat_in;
    logic [DW-1:0]      beat_out;

    assign s_hs      = s_axis_tvalid & s_axis_tready;
    assign rate_cur  = in_pkt_q ? rate_q  : rate_map(s_axis_tuser);
    assign tuser_cur = in_pkt_q ? tuser_q : s_axis_tuser;

    // ext[i +: K] is the K-bit window for input bit i with x[i] at the MSB,
    // matching the generator convention (MSB = delay-0 tap).
    assign ext = {s_axis_tdata, hist_q};

    // Per-bit encode + puncture, packing by a running prefix sum of emitted bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [1:0]     ph;
        logic           a;
        logic           b;
        logic           ea;
        logic           eb;
        logic [TCW-1:0] pos_in;
        logic [TCW-1:0] pos_out;
        logic [CW-1:0]  acc_in;
        logic [CW-1:0]  acc_out;

        if (gi == 0) begin : g_first
            assign pos_in = '0;
            assign acc_in = '0;
        end else begin : g_next
            assign pos_in = g_bit[gi-1].pos_out;
            assign acc_in = g_bit[gi-1].acc_out;
        end

        assign ph      = phase_add(phase_q, gi, rate_cur);
        assign a       = ^(ext[gi +: K] & G0);
        assign b       = ^(ext[gi +: K] & G1);
        assign ea      = emit_a(rate_cur, ph);
        assign eb      = emit_b(rate_cur, ph);
        assign acc_out = acc_in
                       | (CW'(a & ea) << pos_in)
                       | (CW'(b & eb) << (pos_in + TCW'(ea)));
        assign pos_out = pos_in + TCW'(ea) + TCW'(eb);
    end

    assign coded = g_bit[WIDTH-1].acc_out;
    assign count = g_bit[WIDTH-1].pos_out;

    // Packet context clears on acceptance of tlast, independent of the output side.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hist_q   <= '0;
            phase_q  <= '0;
            rate_q   <= RATE_1_2;
            tuser_q  <= '0;
            in_pkt_q <= 1'b0;
        end else if (s_hs) begin
            if (s_axis_tlast) begin
                hist_q   <= '0;
                phase_q  <= '0;
                rate_q   <= RATE_1_2;
                tuser_q  <= '0;
                in_pkt_q <= 1'b0;
            end else begin
                hist_q   <= s_axis_tdata[WIDTH-1 -: H];
                phase_q  <= phase_add(phase_q, WIDTH, rate_cur);
                rate_q   <= rate_cur;
                tuser_q  <= tuser_cur;
                in_pkt_q <= 1'b1;
            end
        end
    end

    assign beat_in = {coded, count, tuser_cur, s_axis_tlast};

    axis_skid_buffer #(
        .DATA_W (DW)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  (beat_in),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  (beat_out),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tcount, m_axis_tuser, m_axis_tlast} = beat_out;

endmodule

// File: doc/conv_encoder_punct.md
Name: conv_encoder_punct

Overview:
Parametrised IEEE 802.11 convolutional encoder with puncturing, AXI4-Stream in and out.
- Constraint length and generator polynomials are parameters.
- Puncture phase is carried across beats, so any WIDTH works with any period.
- Rate is latched once per packet; encoder state resets at packet boundaries.
- Output passes through a registered skid buffer.
- Sits between the scrambler/tail inserter and the interleaver in the TX chain.

Parameters:
- WIDTH, 24: uncoded bits per input beat.
- K, 7: constraint length; history depth is K-1.
- G0, 7'o133: generator polynomial A. MSB = delay-0 tap, LSB = delay K-1 tap.
- G1, 7'o171: generator polynomial B, same convention.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  WIDTH  uncoded bits; bit 0 earliest in time
- s_axis_tuser  in  4  rate code (ieee80211_defs RATE_* macros); sampled on first beat of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (registered)
- s_axis_tlast  in  1  last beat of packet
- m_axis_tdata  out  2*WIDTH  coded bits, LSB-packed, bit 0 earliest; unused upper bits 0
- m_axis_tcount  out  $clog2(2*WIDTH+1)  number of valid coded bits in m_axis_tdata
- m_axis_tuser  out  4  latched rate code of the packet
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last beat of packet

Behaviour:
- Reset: aclk is the only clock; aresetn is asynchronous, active-low. While low, all outputs are 0, including m_axis_tvalid, s_axis_tready, tdata, tcount, tuser and tlast. History, phase, rate latch and skid are cleared. s_axis_tready rises on the first aclk edge after release.
- Reset mid-packet: the in-flight beat is discarded and no partial output is emitted. The next accepted beat is treated as a first beat.
- Encoding: per input bit t, A[t] = XOR of G0 taps over {x[t], x[t-1] .. x[t-K+1]}; B[t] likewise with G1. Bits x[t-1] .. x[t-K+1] come from the history register (initially 0).
- Rate map on the first beat of a packet:
  - RATE_9M/18M/36M/54M -> 3/4
  - RATE_48M -> 2/3
  - any other code -> 1/2
- The latched rate and tuser hold until the tlast beat is accepted. tuser on non-first beats is ignored.
- Puncture, emitted in time order per input bit by phase p:
  - 1/2: period 1; emit A, B.
  - 2/3: period 2; p0 emits A, B; p1 emits A.
  - 3/4: period 3; p0 emits A, B; p1 emits A; p2 emits B.
- Phase is a counter mod period, advancing once per input bit and carried across beats. m_axis_tcount = sum of emitted bits for the beat.
- Handshake/pipeline:
  - s handshake = s_axis_tvalid & s_axis_tready.
  - On an s handshake, history <= top K-1 bits of tdata and phase advances by WIDTH mod period. The encoded beat enters the output register.
  - Latency is 1 cycle: handshake at edge n gives m_axis_tvalid high after edge n. Throughput is 1 beat/cycle with tready held high.
  - Skid buffer holds 2 entries. s_axis_tready = !skid_full, registered. No beat is dropped or duplicated under any tready pattern.
  - m_axis_* are stable while tvalid & !tready.
- Packet boundary: accepting a tlast beat clears history, phase and the rate latch for the next beat. It does not wait for the output handshake. A back-to-back next packet may be accepted on the following cycle.
- Simultaneous s and m handshakes with one entry held: occupancy unchanged, order preserved.

Decomposition:
- Shared package / ieee80211_defs.v: RATE_* codes, puncture period and pattern constants per rate, internal rate enum (RATE_1_2, RATE_2_3, RATE_3_4).
- Puncture/pack logic is a generate loop computing per-bit emit masks and prefix-sum positions from the start phase.
- One sub-module: axis_skid_buffer (DATA_W param; 2-entry, registered ready). Reused across the TX chain.

Test Plan:
- Rate 1/2, WIDTH=8, tuser=RATE_6M, impulse 8'h01 with tlast -> m_axis_tdata=16'h34FB, tcount=16, tlast=1, latency 1 cycle.
- Rate 3/4, WIDTH=8, RATE_54M, three beats 8'h00 -> tcount 11, 11, 10 (32 bits per 24 in), tdata 0, tuser held on all beats.
- Rate 2/3, WIDTH=8, RATE_48M, four beats -> tcount 12 each. tuser changed on beats 2-4 is ignored; m_axis_tuser stays RATE_48M.
- Back-to-back packets: 8'hFF tlast then 8'h01 tlast at rate 1/2 -> second output equals 16'h34FB (history cleared at boundary).
- Backpressure: continuous valid input, m_axis_tready low 5 cycles then random 50% -> s_axis_tready drops after at most 2 beats. Output stream matches the reference model bit-exact, with no loss or duplication.
- Reset mid-packet: aresetn low asynchronously between edges during beat 2 of 4 -> all outputs 0 immediately. After release, a new packet encodes from zero history and phase 0.
